rc4_sbox_ctrl: RTL and testbench

- RC4 cipher engine front end that drives the 256-byte S-box RAM and turns it into a keystream byte source.
- The S-box RAM has two combinational read ports and two write ports that commit together on one enable.
- Runs three phases in order: S-box init, KSA (key scheduling), then PRGA (keystream generation).
- Keystream bytes go downstream over a valid/ready stream, ready for the XOR/data-path stage.

---
 rtl/rc4_sbox_ctrl_if.sv | 24 ++
 rtl/rc4_sbox_ctrl.sv | 158 +++++++++++++++
 tb/tb_rc4_sbox_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rc4_sbox_ctrl_if.sv
// Keystream stream plus the two-read/two-write S-box RAM port bundle.
interface rc4_sbox_ctrl_if;
  logic [7:0] ks_data;
  logic       ks_valid;
  logic       ks_ready;
  logic [7:0] s_raddr;
  logic [7:0] s_rdata_a;
  logic [7:0] s_waddr;
  logic [7:0] s_wdata_a;
  logic [7:0] s_addr;
  logic [7:0] s_wdata_b;
  logic [7:0] s_rdata_b;
  logic       s_wen;

  modport master (
    output ks_data, ks_valid, s_raddr, s_waddr, s_wdata_a, s_addr, s_wdata_b, s_wen,
    input  ks_ready, s_rdata_a, s_rdata_b
  );

  modport slave (
    input  ks_data, ks_valid, s_raddr, s_waddr, s_wdata_a, s_addr, s_wdata_b, s_wen,
    output ks_ready, s_rdata_a, s_rdata_b
  );
endinterface

// File: rtl/rc4_sbox_ctrl.sv
// RC4 front end: S-box init, KSA, then PRGA over an external combinational S-box RAM.
// First byte 772 cycles after start, then 4 cycles/byte; ks_data/ks_valid held while ks_ready=0.
module rc4_sbox_ctrl #(
  parameter int KEY_BYTES = 16,
  parameter int DROP      = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [15:0]            len,
  output logic                   busy,
  output logic                   done,
  rc4_sbox_ctrl_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE, INIT, KSA_RD, KSA_SW, PRGA_RD, PRGA_SW, PRGA_OUT, HOLD
  } state_t;

  localparam logic [7:0]  K_LAST = 8'(KEY_BYTES - 1);
  localparam logic [15:0] DROP_L = 16'(DROP);

  state_t      state;
  logic [7:0]  i, j, k, si, t;
  logic [15:0] byte_cnt, drop_cnt, len_q;
  logic [7:0]  key_byte;

  always_comb begin
    key_byte = 8'h00;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (k == 8'(n)) key_byte = key[8*n +: 8];
    end
  end

  // done is registered one transition early so it coincides with the final PRGA_RD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      i            <= 8'h00;
      j            <= 8'h00;
      k            <= 8'h00;
      si           <= 8'h00;
      t            <= 8'h00;
      byte_cnt     <= 16'h0000;
      drop_cnt     <= 16'h0000;
      len_q        <= 16'h0000;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.ks_data  <= 8'h00;
      bus.ks_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            i        <= 8'h00;
            j        <= 8'h00;
            k        <= 8'h00;
            byte_cnt <= 16'h0000;
            drop_cnt <= 16'h0000;
            busy     <= 1'b1;
            state    <= INIT;
          end
        end
        INIT: begin
          i <= i + 8'd1;
          if (i == 8'hFF) state <= KSA_RD;
        end
        KSA_RD: begin
          si    <= bus.s_rdata_a;
          j     <= j + bus.s_rdata_a + key_byte;
          state <= KSA_SW;
        end
        KSA_SW: begin
          k <= (k == K_LAST) ? 8'h00 : k + 8'd1;
          if (i == 8'hFF) begin
            i     <= 8'h01;
            j     <= 8'h00;
            done  <= (len_q == 16'h0000);
            state <= PRGA_RD;
          end else begin
            i     <= i + 8'd1;
            state <= KSA_RD;
          end
        end
        PRGA_RD: begin
          if (byte_cnt == len_q) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            si    <= bus.s_rdata_a;
            j     <= j + bus.s_rdata_a;
            state <= PRGA_SW;
          end
        end
        PRGA_SW: begin
          t     <= si + bus.s_rdata_b;
          state <= PRGA_OUT;
        end
        PRGA_OUT: begin
          if (drop_cnt != DROP_L) begin
            drop_cnt <= drop_cnt + 16'd1;
            i        <= i + 8'd1;
            done     <= (byte_cnt == len_q);
            state    <= PRGA_RD;
          end else begin
            bus.ks_data  <= bus.s_rdata_a;
            bus.ks_valid <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (bus.ks_ready) begin
            bus.ks_valid <= 1'b0;
            byte_cnt     <= byte_cnt + 16'd1;
            i            <= i + 8'd1;
            done         <= (byte_cnt + 16'd1 == len_q);
            state        <= PRGA_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Swap states: port B reads old S[j] and writes old S[i]; port A writes old S[j] into S[i].
  always_comb begin
    bus.s_raddr   = 8'h00;
    bus.s_waddr   = 8'h00;
    bus.s_wdata_a = 8'h00;
    bus.s_addr    = 8'h00;
    bus.s_wdata_b = 8'h00;
    bus.s_wen     = 1'b0;
    case (state)
      INIT: begin
        bus.s_waddr   = i;
        bus.s_addr    = i;
        bus.s_wdata_a = i;
        bus.s_wdata_b = i;
        bus.s_wen     = 1'b1;
      end
      KSA_RD:   bus.s_raddr = i;
      KSA_SW, PRGA_SW: begin
        bus.s_addr    = j;
        bus.s_waddr   = i;
        bus.s_wdata_a = bus.s_rdata_b;
        bus.s_wdata_b = si;
        bus.s_wen     = 1'b1;
      end
      PRGA_RD:  if (byte_cnt != len_q) bus.s_raddr = i;
      PRGA_OUT: bus.s_raddr = t;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_sbox_ctrl.sv
// Four engines (Key, Wiki, Secret, Key with drop 2) each with its own S-box RAM, checked against known RC4 keystreams.
module tb_rc4_sbox_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_w    [4];
  logic [47:0] key_w      [4];
  logic [15:0] len_w      [4];
  logic        busy_w     [4];
  logic        done_w     [4];
  logic        ks_valid_w [4];
  logic        ks_ready_w [4];
  logic        s_wen_w    [4];
  logic [7:0]  ks_data_w  [4];
  logic [7:0]  sbox_or_w  [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int KB = (g == 1) ? 4 : (g == 2) ? 6 : 3;
    localparam int DR = (g == 3) ? 2 : 0;

    rc4_sbox_ctrl_if u_if ();
    logic [7:0] mem [256];

    rc4_sbox_ctrl #(.KEY_BYTES(KB), .DROP(DR)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_w[g]),
      .key   (key_w[g][8*KB-1:0]),
      .len   (len_w[g]),
      .busy  (busy_w[g]),
      .done  (done_w[g]),
      .bus   (u_if)
    );

    assign u_if.s_rdata_a = mem[u_if.s_raddr];
    assign u_if.s_rdata_b = mem[u_if.s_addr];
    assign u_if.ks_ready  = ks_ready_w[g];
    assign ks_valid_w[g]  = u_if.ks_valid;
    assign ks_data_w[g]   = u_if.ks_data;
    assign s_wen_w[g]     = u_if.s_wen;
    assign sbox_or_w[g]   = u_if.s_raddr | u_if.s_waddr | u_if.s_addr | u_if.s_wdata_a | u_if.s_wdata_b;

    always @(posedge clk) begin
      if (u_if.s_wen) begin
        mem[u_if.s_waddr] <= u_if.s_wdata_a;
        mem[u_if.s_addr]  <= u_if.s_wdata_b;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input int g, input string tag);
    check({tag, "_busy"}, busy_w[g], 0);
    check({tag, "_done"}, done_w[g], 0);
    check({tag, "_vld"}, ks_valid_w[g], 0);
    check({tag, "_data"}, ks_data_w[g], 0);
    check({tag, "_wen"}, s_wen_w[g], 0);
    check({tag, "_sbox"}, sbox_or_w[g], 0);
  endtask

  // One run: start at edge T, cycle T+c is observed at the c-th following negedge.
  task automatic run(input int g, input logic [15:0] n, input int stall, input logic [127:0] exp,
                     input int exp_first, input int exp_done, input int poke, input string tag);
    int cyc = 0, got = 0, first = -1, done_at = -1, stall_left = 0;
    int limit = 850 + int'(n) * (12 + stall);
    bit pend = 0, fin = 0;
    logic [7:0] held = 8'h00;
    @(negedge clk);
    len_w[g]      = n;
    start_w[g]    = 1'b1;
    ks_ready_w[g] = (stall == 0);
    @(posedge clk);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start_w[g] = (cyc == poke);
      if (cyc == poke) check({tag, "_busy_poke"}, busy_w[g], 1);
      if (ks_valid_w[g]) begin
        if (first < 0) first = cyc;
        if (!pend) begin
          pend = 1;
          held = ks_data_w[g];
          stall_left = stall;
          if (got < int'(n)) check($sformatf("%s_b%0d", tag, got), ks_data_w[g], exp[8*(int'(n)-1-got) +: 8]);
          else check({tag, "_extra"}, got + 1, n);
        end else begin
          check({tag, "_hold_data"}, ks_data_w[g], held);
        end
        if (stall_left > 0) begin
          ks_ready_w[g] = 1'b0;
          stall_left--;
        end else begin
          ks_ready_w[g] = 1'b1;
          pend = 0;
          got++;
        end
      end else begin
        if (pend) check({tag, "_hold_vld"}, ks_valid_w[g], 1);
        ks_ready_w[g] = (stall == 0);
      end
      if (done_w[g]) begin
        done_at = cyc;
        fin = 1;
      end else if (cyc > limit) begin
        check({tag, "_timeout"}, done_w[g], 1);
        fin = 1;
      end
    end
    check({tag, "_count"}, got, n);
    check({tag, "_done_at"}, done_at, exp_done);
    check({tag, "_first_vld"}, first, exp_first);
    @(negedge clk);
    check({tag, "_done_pulse"}, done_w[g], 0);
    check({tag, "_busy_end"}, busy_w[g], 0);
    ks_ready_w[g] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 4; g++) begin
      start_w[g]    = 1'b0;
      len_w[g]      = 16'd0;
      ks_ready_w[g] = 1'b1;
    end
    key_w[0] = 48'h0000_0079_654B;   // "Key"
    key_w[1] = 48'h0000_696B_6957;   // "Wiki"
    key_w[2] = 48'h7465_7263_6553;   // "Secret"
    key_w[3] = 48'h0000_0079_654B;   // "Key", drop 2
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 4; g++) check_idle_outputs(g, $sformatf("rst%0d", g));
    rst_n = 1'b1;

    run(0, 16'd10, 0, 128'hEB9F7781B734CA72A719, 772, 809, -1, "key10");
    run(0, 16'd0,  0, 128'h0, -1, 769, 100, "len0");
    run(1, 16'd6,  0, 128'h6044DB6D41B7, 772, 793, -1, "wiki_a");
    run(1, 16'd6,  0, 128'h6044DB6D41B7, 772, 793, -1, "wiki_b");
    run(2, 16'd8,  5, 128'h04D46B053CA87B59, 772, 841, -1, "secret");
    run(3, 16'd3,  0, 128'h7781B7, 778, 787, -1, "drop2");

    // Abort a run while a byte is held, then confirm a clean restart.
    @(negedge clk);
    len_w[0]      = 16'd10;
    ks_ready_w[0] = 1'b0;
    start_w[0]    = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    for (int c = 0; c < 900 && !ks_valid_w[0]; c++) @(negedge clk);
    check("mid_vld", ks_valid_w[0], 1);
    check("mid_byte", ks_data_w[0], 8'hEB);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs(0, "mid_rst");
    @(negedge clk);
    check("mid_rst_wen2", s_wen_w[0], 0);
    check("mid_rst_busy2", busy_w[0], 0);
    ks_ready_w[0] = 1'b1;
    run(0, 16'd3, 0, 128'hEB9F77, 772, 781, -1, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
